// File: rtl/axi_avst_pkg.sv
// Shared types and helpers for the AXI4-Stream to Avalon-ST framer.
// The beat struct is sized from the package widths, so the top-level defaults must match them.
package axi_avst_pkg;

    localparam int unsigned AVST_DATA_WIDTH  = 512;
    localparam int unsigned AVST_NO_OF_BYTES = AVST_DATA_WIDTH / 8;
    localparam int unsigned AVST_EMPTY_BITS  = $clog2(AVST_NO_OF_BYTES);

    typedef enum logic {
        IDLE,
        IN_PKT
    } frame_state_e;

    typedef struct packed {
        logic [AVST_DATA_WIDTH-1:0] data;
        logic [AVST_EMPTY_BITS-1:0] empty;
        logic                       sop;
        logic                       eop;
        logic                       error;
    } avst_beat_t;

    // Unused bytes above the highest enabled byte; an all-zero keep maps to 0.
    function automatic logic [AVST_EMPTY_BITS-1:0] keep_to_empty(
        input logic [AVST_NO_OF_BYTES-1:0] keep
    );
        logic [AVST_EMPTY_BITS-1:0] empty;
        empty = '0;
        for (int unsigned i = 0; i < AVST_NO_OF_BYTES; i++) begin
            if (keep[i]) empty = AVST_EMPTY_BITS'(AVST_NO_OF_BYTES - 1 - i);
        end
        return empty;
    endfunction

    // keep is contiguous from bit 0 exactly when keep & (keep + 1) is zero.
    function automatic logic keep_malformed(
        input logic [AVST_NO_OF_BYTES-1:0] keep,
        input logic                        last
    );
        logic bad;
        if (last) bad = (keep == '0) || ((keep & (keep + 1'b1)) != '0);
        else      bad = (keep != '1);
        return bad;
    endfunction

endpackage

// File: rtl/axis_avst_skid.sv
// Two-entry skid buffer with a registered upstream ready; head entry drives the outputs directly.
module axis_avst_skid #(
    parameter type beat_t = logic [7:0]
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    output logic  in_ready,
    input  beat_t in_beat,
    output logic  out_valid,
    input  logic  out_ready,
    output beat_t out_beat
);

    beat_t      head_q, head_d;
    beat_t      tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    logic       push;
    logic       pop;

    always_comb begin
        pop    = (count_q != 2'd0) && out_ready;
        push   = in_valid && (in_ready_q || pop);
        head_d = head_q;
        tail_d = tail_q;
        if (pop) head_d = tail_q;
        // Incoming beat lands in whichever slot is first free after any pop.
        if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) head_d = in_beat;
            else                                                 tail_d = in_beat;
        end
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_beat  = head_q;

endmodule

// File: rtl/axis2avst_framer.sv
// AXI4-Stream to Avalon-ST framer: SOP generation, tkeep-to-empty, input register and skid-buffered output.
module axis2avst_framer
    import axi_avst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = AVST_DATA_WIDTH,
    parameter int unsigned NO_OF_BYTES = DATA_WIDTH / 8,
    parameter int unsigned EMPTY_BITS  = $clog2(NO_OF_BYTES),
    parameter int unsigned USER_WIDTH  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axis_tvalid,
    output logic                   axis_tready,
    input  logic [DATA_WIDTH-1:0]  axis_tdata,
    input  logic [NO_OF_BYTES-1:0] axis_tkeep,
    input  logic                   axis_tlast,
    input  logic [USER_WIDTH-1:0]  axis_tuser,
    output logic                   avst_valid,
    input  logic                   avst_ready,
    output logic [DATA_WIDTH-1:0]  avst_data,
    output logic                   avst_startofpacket,
    output logic                   avst_endofpacket,
    output logic [EMPTY_BITS-1:0]  avst_empty,
    output logic                   avst_error,
    output logic [31:0]            stat_pkt_cnt,
    output logic                   stat_keep_err
);

    frame_state_e           state_q, state_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]  s1_data_q, s1_data_d;
    logic [NO_OF_BYTES-1:0] s1_keep_q, s1_keep_d;
    logic                   s1_last_q, s1_last_d;
    logic                   s1_sop_q, s1_sop_d;
    logic                   s1_error_q, s1_error_d;
    logic                   keep_err_q, keep_err_d;
    logic [31:0]            pkt_cnt_q, pkt_cnt_d;

    logic       skid_ready;
    logic       accept;
    logic       deliver;
    logic       s1_take;
    avst_beat_t s1_beat;
    avst_beat_t out_beat;

    assign accept  = axis_tvalid && skid_ready;
    assign deliver = avst_valid && avst_ready;
    // Mirrors the skid push condition; accept implies the stage-1 beat drains this cycle.
    assign s1_take = s1_valid_q && (skid_ready || deliver);

    always_comb begin
        s1_beat.data  = s1_data_q;
        s1_beat.empty = s1_last_q ? keep_to_empty(s1_keep_q) : '0;
        s1_beat.sop   = s1_sop_q;
        s1_beat.eop   = s1_last_q;
        s1_beat.error = s1_error_q;
    end

    always_comb begin
        state_d    = state_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_keep_d  = s1_keep_q;
        s1_last_d  = s1_last_q;
        s1_sop_d   = s1_sop_q;
        s1_error_d = s1_error_q;
        if (s1_take) s1_valid_d = 1'b0;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = axis_tdata;
            s1_keep_d  = axis_tkeep;
            s1_last_d  = axis_tlast;
            s1_sop_d   = (state_q == IDLE);
            s1_error_d = |axis_tuser;
            state_d    = axis_tlast ? IDLE : IN_PKT;
        end
        keep_err_d = accept && keep_malformed(axis_tkeep, axis_tlast);
        pkt_cnt_d  = pkt_cnt_q + ((deliver && out_beat.eop) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_keep_q  <= '0;
            s1_last_q  <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_error_q <= 1'b0;
            keep_err_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_keep_q  <= s1_keep_d;
            s1_last_q  <= s1_last_d;
            s1_sop_q   <= s1_sop_d;
            s1_error_q <= s1_error_d;
            keep_err_q <= keep_err_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    axis_avst_skid #(
        .beat_t(avst_beat_t)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s1_valid_q),
        .in_ready (skid_ready),
        .in_beat  (s1_beat),
        .out_valid(avst_valid),
        .out_ready(avst_ready),
        .out_beat (out_beat)
    );

    assign axis_tready        = skid_ready;
    assign avst_data          = out_beat.data;
    assign avst_startofpacket = out_beat.sop;
    assign avst_endofpacket   = out_beat.eop;
    assign avst_empty         = out_beat.empty;
    assign avst_error         = out_beat.error;
    assign stat_pkt_cnt       = pkt_cnt_q;
    assign stat_keep_err      = keep_err_q;

endmodule
